// File: rtl/multiples_sum_engine.sv
// rtl/multiples_sum_engine.sv - sums 1 <= n < limit divisible by any of NUM_DIV run-time divisors
// Optional hit_count output enabled by defining MULT_SUM_COUNT_EN.
module multiples_sum_engine #(
    parameter int WIDTH     = 32,
    parameter int N_WIDTH   = 16,
    parameter int NUM_DIV   = 2,
    parameter int DIV_WIDTH = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [N_WIDTH-1:0]           limit,
    input  logic [NUM_DIV*DIV_WIDTH-1:0] divisors,
    output logic                         busy,
    output logic                         done,
    output logic [WIDTH-1:0]             result,
    output logic                         overflow
`ifdef MULT_SUM_COUNT_EN
    ,
    output logic [N_WIDTH-1:0]           hit_count
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [N_WIDTH-1:0]   N_ONE   = N_WIDTH'(1);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE = DIV_WIDTH'(1);

    logic [1:0]           state;
    logic [N_WIDTH-1:0]   lim_q;
    logic [N_WIDTH-1:0]   n_q;
    logic [WIDTH-1:0]     acc_q;
    logic [DIV_WIDTH-1:0] d_q [NUM_DIV];
    logic [DIV_WIDTH-1:0] r_q [NUM_DIV];
    logic [DIV_WIDTH-1:0] r_nxt [NUM_DIV];
`ifdef MULT_SUM_COUNT_EN
    logic [N_WIDTH-1:0]   cnt_q;
`endif

    logic             accept;
    logic             last;
    logic             hit;
    logic             add_en;
    logic [WIDTH:0]   sum_ext;

    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);
    assign accept  = start && ((state == S_IDLE) || (state == S_DONE));
    assign last    = (lim_q <= N_ONE) || (n_q == (lim_q - N_ONE));
    // With lim_q <= 1 there is no valid n, so the single RUN cycle must add nothing.
    assign add_en  = hit && (lim_q > N_ONE);
    assign sum_ext = {1'b0, acc_q} + {{(WIDTH + 1 - N_WIDTH){1'b0}}, n_q};

    // Residue counters replace n % d: r[i] tracks n mod d_q[i] and wraps at d_q[i]-1.
    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_DIV; i++) begin
            r_nxt[i] = (r_q[i] == (d_q[i] - DIV_ONE)) ? '0 : (r_q[i] + DIV_ONE);
            if ((d_q[i] != '0) && (r_q[i] == '0)) begin
                hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            lim_q    <= '0;
            n_q      <= '0;
            acc_q    <= '0;
            result   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_DIV; i++) begin
                d_q[i] <= '0;
                r_q[i] <= '0;
            end
`ifdef MULT_SUM_COUNT_EN
            cnt_q     <= '0;
            hit_count <= '0;
`endif
        end else if (accept) begin
            state    <= S_RUN;
            lim_q    <= limit;
            n_q      <= N_ONE;
            acc_q    <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_DIV; i++) begin
                d_q[i] <= divisors[i*DIV_WIDTH +: DIV_WIDTH];
                r_q[i] <= (divisors[i*DIV_WIDTH +: DIV_WIDTH] == DIV_ONE) ? '0 : DIV_ONE;
            end
`ifdef MULT_SUM_COUNT_EN
            cnt_q <= '0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    if (add_en) begin
                        acc_q <= sum_ext[WIDTH-1:0];
                        if (sum_ext[WIDTH]) begin
                            overflow <= 1'b1;
                        end
`ifdef MULT_SUM_COUNT_EN
                        cnt_q <= cnt_q + N_ONE;
`endif
                    end
                    for (int i = 0; i < NUM_DIV; i++) begin
                        if (d_q[i] != '0) begin
                            r_q[i] <= r_nxt[i];
                        end
                    end
                    if (last) begin
                        state  <= S_DONE;
                        result <= add_en ? sum_ext[WIDTH-1:0] : acc_q;
`ifdef MULT_SUM_COUNT_EN
                        hit_count <= add_en ? (cnt_q + N_ONE) : cnt_q;
`endif
                    end else begin
                        n_q <= n_q + N_ONE;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multiples_sum_engine.sv
// tb/tb_multiples_sum_engine.sv - scoreboard bench for multiples_sum_engine (32-bit and 16-bit builds)
module tb_multiples_sum_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] limit;
    logic [15:0] divisors;
    logic        busy, done, overflow;
    logic [31:0] result;
    logic        busy16, done16, overflow16;
    logic [15:0] result16;
`ifdef MULT_SUM_COUNT_EN
    logic [15:0] hit_count, hit_count16;
`endif

    typedef struct {
        longint sum;
        int     cnt;
        int     lat;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    multiples_sum_engine dut (
        .clk(clk), .rst_n(rst_n), .start(start), .limit(limit), .divisors(divisors),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
`ifdef MULT_SUM_COUNT_EN
        , .hit_count(hit_count)
`endif
    );

    multiples_sum_engine #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start), .limit(limit), .divisors(divisors),
        .busy(busy16), .done(done16), .result(result16), .overflow(overflow16)
`ifdef MULT_SUM_COUNT_EN
        , .hit_count(hit_count16)
`endif
    );

    function automatic void model(input int lim, input int d0, input int d1,
                                  output longint s, output int c);
        s = 0;
        c = 0;
        for (int n = 1; n < lim; n++) begin
            if ((d0 != 0 && n % d0 == 0) || (d1 != 0 && n % d1 == 0)) begin
                s += n;
                c++;
            end
        end
    endfunction

    task automatic issue(input int lim, input int d0, input int d1, input bit push);
        exp_t   e;
        longint s;
        int     c;
        model(lim, d0, d1, s, c);
        e.sum = s;
        e.cnt = c;
        e.lat = 1 + ((lim > 1) ? lim - 1 : 1);
        if (push) sb.push_back(e);
        start    = 1'b1;
        limit    = lim[15:0];
        divisors = {d1[7:0], d0[7:0]};
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int cnt0);
        int   cyc = cnt0;
        bit   seen = 0;
        bit   gap = 0;
        exp_t e;
        while (!seen && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1;
            else if (!busy) gap = 1;
        end
        n_cmp++;
        if (!seen || sb.size() == 0) begin
            n_bad++;
            $display("FAIL %s done_wait: seen=%0b queued=%0d, required done pulse with queued result", name, seen, sb.size());
            return;
        end
        e = sb.pop_front();
        n_cmp++;
        if (result !== e.sum[31:0]) begin
            n_bad++;
            $display("FAIL %s result: got %0d, expected %0d", name, result, e.sum[31:0]);
        end
        n_cmp++;
        if (overflow !== ((e.sum >> 32) != 0)) begin
            n_bad++;
            $display("FAIL %s overflow: got %0b, expected %0b", name, overflow, (e.sum >> 32) != 0);
        end
        n_cmp++;
        if (cyc !== e.lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d, expected %0d", name, cyc, e.lat);
        end
        n_cmp++;
        if (gap !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy: gap=%0b busy_at_done=%0b, expected 0 and 0", name, gap, busy);
        end
`ifdef MULT_SUM_COUNT_EN
        n_cmp++;
        if (hit_count !== e.cnt[15:0]) begin
            n_bad++;
            $display("FAIL %s hit_count: got %0d, expected %0d", name, hit_count, e.cnt);
        end
`endif
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; limit = '0; divisors = '0;
        #12;
        n_cmp++;
        if ({busy, done, overflow, result} !== 35'd0 || {busy16, done16, overflow16, result16} !== 19'd0) begin
            n_bad++;
            $display("FAIL reset_state: busy=%0b done=%0b ovf=%0b result=%0d result16=%0d, expected all 0",
                     busy, done, overflow, result, result16);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        issue(1000, 3, 5, 1);
        wait_done("basic_3_5_1000", 0);
        @(negedge clk);
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || result !== 32'd233168) begin
            n_bad++;
            $display("FAIL basic_hold: done=%0b busy=%0b result=%0d, expected 0 0 233168", done, busy, result);
        end
    endtask

    task automatic test_back_to_back();
        issue(10, 3, 5, 1);
        wait_done("b2b_first", 0);
        issue(50, 7, 0, 1);
        wait_done("b2b_second", 0);
    endtask

    task automatic test_zero_limits();
        issue(100, 0, 0, 1);
        wait_done("disabled_divs", 0);
        issue(0, 3, 5, 1);
        wait_done("limit0", 0);
        issue(1, 1, 1, 1);
        wait_done("limit1", 0);
    endtask

    task automatic test_overflow();
        longint s;
        int     c;
        model(1000, 3, 5, s, c);
        issue(1000, 3, 5, 1);
        wait_done("wide_run", 0);
        n_cmp++;
        if (done16 !== 1'b1 || result16 !== s[15:0] || overflow16 !== 1'b1) begin
            n_bad++;
            $display("FAIL w16_overflow: done=%0b result=%0d ovf=%0b, expected 1 %0d 1", done16, result16, overflow16, s[15:0]);
        end
        issue(10, 3, 5, 1);
        wait_done("wide_small", 0);
        n_cmp++;
        if (done16 !== 1'b1 || result16 !== 16'd23 || overflow16 !== 1'b0) begin
            n_bad++;
            $display("FAIL w16_clear: done=%0b result=%0d ovf=%0b, expected 1 23 0", done16, result16, overflow16);
        end
    endtask

    task automatic test_div_one();
        issue(5, 1, 2, 1);
        wait_done("div_one", 0);
    endtask

    task automatic test_reset_mid_run();
        bit stray = 0;
        @(negedge clk);
        issue(1000, 3, 5, 0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, overflow, result} !== 35'd0 || {busy16, done16, overflow16, result16} !== 19'd0) begin
            n_bad++;
            $display("FAIL async_reset: busy=%0b done=%0b ovf=%0b result=%0d result16=%0d, expected all 0",
                     busy, done, overflow, result, result16);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (done || busy) stray = 1;
        end
        n_cmp++;
        if (stray !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_abandon: activity=%0b after reset, expected 0", stray);
        end
        issue(20, 3, 5, 1);
        wait_done("after_reset", 0);
    endtask

    task automatic test_start_during_run();
        @(negedge clk);
        issue(100, 3, 5, 1);
        repeat (3) @(negedge clk);
        start    = 1'b1;
        limit    = 16'd500;
        divisors = {8'd0, 8'd7};
        @(negedge clk);
        start = 1'b0;
        wait_done("start_ignored", 4);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero_limits();
        test_overflow();
        test_div_one();
        test_reset_mid_run();
        test_start_during_run();
        n_cmp++;
        if (sb.size() !== 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multiples_sum_engine.md
Name: multiples_sum_engine

Overview:
- Parametrised successor to the fixed-divisor multiples-sum solver.
- Computes the sum of all n with 1 <= n < limit that are divisible by at least one of NUM_DIV run-time divisors.
- Uses a start/busy/done handshake and is restartable.
- Replaces per-cycle modulo operators with per-divisor residue counters.
- Flags accumulator overflow.

Parameters:
- WIDTH, 32: accumulator/result width in bits.
- N_WIDTH, 16: width of the limit input and of the internal n counter.
- NUM_DIV, 2: number of divisor channels, 1..4.
- DIV_WIDTH, 8: width of each divisor.

Ports:
- clk  in  1: rising-edge clock.
- rst_n  in  1: asynchronous active-low reset.
- start  in  1: one-cycle request; sampled only in IDLE or DONE.
- limit  in  N_WIDTH: exclusive upper bound; sampled on accepted start.
- divisors  in  NUM_DIV*DIV_WIDTH: divisor i occupies bits [i*DIV_WIDTH +: DIV_WIDTH]; sampled on accepted start.
- busy  out  1: high while in RUN.
- done  out  1: one-cycle pulse when the result becomes valid.
- result  out  WIDTH: sum modulo 2^WIDTH; held until the next accepted start.
- overflow  out  1: sticky; set if any addition carried out of WIDTH bits during the run.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy=0, done=0, result=0, overflow=0; all internal counters and registers cleared. This applies mid-run too: the run is abandoned and no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --(n == lim_q-1, or lim_q <= 1)--> DONE.
  - DONE --start--> RUN.
  - DONE --no start--> IDLE.
- Accepted start (state IDLE or DONE, start=1):
  - Latch lim_q=limit and d_q[i]=divisors[i].
  - Set n=1 and acc=0; clear overflow.
  - Load each residue r[i] = (d_q[i]==1) ? 0 : 1.
  - busy rises on the next cycle.
- start while in RUN: ignored; latched values are unaffected.
- RUN, one n per cycle:
  - hit = OR over i of (d_q[i] != 0 && r[i] == 0).
  - If hit: acc <= acc + n, zero-extended to WIDTH+1 bits. A carry sets overflow; acc keeps the low WIDTH bits.
  - n <= n+1.
  - Each r[i] <= (r[i] == d_q[i]-1) ? 0 : r[i]+1, applied only when d_q[i] != 0.
- Divisor 0 disables its channel. Divisor 1 hits every n.
- Termination:
  - In the cycle where n == lim_q-1, that n is still evaluated and added; then go to DONE.
  - If lim_q is 0 or 1, RUN lasts exactly one cycle, adds nothing, then goes to DONE.
- Latency: from an accepted start at cycle T, done pulses at T+1+max(lim_q-1, 1).
- Entering DONE: result <= final acc; done=1 for exactly one cycle; busy=0.
- result and overflow are stable from the done pulse until the next accepted start. During RUN, result keeps the previous run's value.
- n never wraps: the largest n is lim_q-1 < 2^N_WIDTH.
- Simultaneous start and done cycle: a start in DONE is accepted immediately, giving back-to-back runs with no IDLE cycle.

Optional Feature:
- Macro: MULT_SUM_COUNT_EN.
- When defined:
  - Adds output port hit_count (out, N_WIDTH): the number of hit n values in the last run.
  - Reset value 0; cleared on accepted start; updated with result on entering DONE; held thereafter.
  - Incremented in RUN on each hit.
- When undefined: the port and its counter do not exist, and all other behaviour is identical.

Test Plan:
- Divisors {3,5}, limit=1000, start -> done exactly 1000 cycles after the start cycle; result=233168; overflow=0; with MULT_SUM_COUNT_EN, hit_count=466.
- Divisors {3,5}, limit=10 -> result=23; then immediately restart on the done cycle with divisors {7,0}, limit=50 -> result=196 (7+14+...+49); busy stays continuous except during the done cycle.
- Divisors {0,0}, limit=100 -> result=0, done after 100 cycles. Limit=0 and limit=1 (any divisors) -> result=0, done 2 cycles after start.
- WIDTH=16 override, divisors {3,5}, limit=1000 -> result=36560 (233168 mod 65536); overflow=1. Next run with limit=10 -> overflow cleared, result=23.
- Divisors {1,2}, limit=5 -> result=10. Assert rst_n low for 1 cycle at cycle 3 of a limit=1000 run -> busy, done, result and overflow are all 0 asynchronously; no done pulse follows; a fresh start then gives correct results.
- start pulsed again during RUN with different limit/divisors -> ignored; first run's result is unchanged.
